writeback_regfile_par: RTL

WRITEBACK_REGFILE_PAR -- requirements
Module: writeback_regfile_par

---
 rtl/writeback_regfile_pkg.sv | 22 ++
 rtl/writeback_regfile_par_nzp_gen.sv | 15 +
 rtl/writeback_regfile_par.sv | 72 +++++++
 3 files changed

// File: rtl/writeback_regfile_pkg.sv
// Shared condition-code definitions for the writeback register file:
// psr bit positions, reset value and the N/Z/P encoding helper.
package writeback_regfile_pkg;

    typedef logic [2:0] nzp_t;

    localparam int unsigned PSR_N_BIT = 2;
    localparam int unsigned PSR_Z_BIT = 1;
    localparam int unsigned PSR_P_BIT = 0;
    localparam nzp_t        PSR_RESET = 3'b010;

    // Width-independent encoder: callers reduce their data to sign and zero flags.
    function automatic nzp_t nzp_from_flags(input logic neg, input logic zero);
        nzp_t cc;
        cc = '0;
        if (neg)       cc[PSR_N_BIT] = 1'b1;
        else if (zero) cc[PSR_Z_BIT] = 1'b1;
        else           cc[PSR_P_BIT] = 1'b1;
        return cc;
    endfunction

endpackage

// File: rtl/writeback_regfile_par_nzp_gen.sv
// Combinational two's-complement condition-code generator for a DATA_W-bit value.
module nzp_gen
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] data,
    output logic [2:0]        nzp
);

    always_comb begin
        nzp = nzp_from_flags(data[DATA_W-1], data == '0);
    end

endmodule

// File: rtl/writeback_regfile_par.sv
// Flop-array register file with registered dual read ports, write-to-read
// forwarding and a processor status register fed by writebacks or direct loads.
module writeback_regfile_par
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 8,
    parameter int PSR_ON_WB = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              writeback_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] sr1_addr,
    input  logic [ADDR_W-1:0] sr2_addr,
    input  logic              psr_load,
    input  logic [2:0]        psr_load_val,
    output logic              writeback_en_out,
    output logic [2:0]        psr,
    output logic [DATA_W-1:0] VSR1,
    output logic [DATA_W-1:0] VSR2
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [2:0]        wb_cc;
    logic              fwd1;
    logic              fwd2;

    nzp_gen #(.DATA_W(DATA_W)) u_nzp_gen (
        .data (w_data),
        .nzp  (wb_cc)
    );

    always_comb begin
        fwd1 = writeback_en && (sr1_addr == w_addr);
        fwd2 = writeback_en && (sr2_addr == w_addr);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            VSR1             <= '0;
            VSR2             <= '0;
            psr              <= PSR_RESET;
            writeback_en_out <= 1'b0;
        end else begin
            writeback_en_out <= writeback_en;

            if (writeback_en) begin
                regs[w_addr] <= w_data;
            end

            // Read ports see the value being written this cycle, not the stale entry.
            if (rd_en) begin
                VSR1 <= fwd1 ? w_data : regs[sr1_addr];
                VSR2 <= fwd2 ? w_data : regs[sr2_addr];
            end

            if (psr_load) begin
                psr <= psr_load_val;
            end else if ((PSR_ON_WB != 0) && writeback_en) begin
                psr <= wb_cc;
            end
        end
    end

endmodule
